// File: rtl/secuenciador_control.sv
// secuenciador_control: multi-cycle fetch/decode/exec/pc-update sequencer.
// Drives PC strobes, fetch handshake and write-back enables.
module secuenciador_control #(
    parameter int OPW         = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           RUN,
    input  logic           STEP_MODE,
    input  logic           STEP,
    input  logic           MEM_READY,
    input  logic [OPW-1:0] OPCODE,
    input  logic [2:0]     COND,
    input  logic [3:0]     FLAGS,
    output logic           MEM_REQ,
    output logic           IR_LOAD,
    output logic           REG_WE,
    output logic           FLAGS_LOAD,
    output logic           WPC,
    output logic           UC,
    output logic           ALU_TAKEN,
    output logic           HALTED,
    output logic           ERROR,
    output logic [2:0]     STATE
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_PCUPD  = 3'd4,
        S_PAUSE  = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_NOP   = 3'd0,
        C_ALU   = 3'd1,
        C_JMP   = 3'd2,
        C_BCOND = 3'd3,
        C_HALT  = 3'd4,
        C_ILL   = 3'd5
    } cls_t;

    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    state_t      state, state_n;
    cls_t        cls, op_cls;
    logic        taken, cond_true;
    logic [7:0]  wait_cnt;
    logic [31:0] op_u;

    // Classify the opcode currently presented by the instruction register.
    always_comb begin
        op_u   = 32'(OPCODE);
        op_cls = C_ILL;
        unique case (1'b1)
            (op_u == 32'd0):                    op_cls = C_NOP;
            (op_u >= 32'd1 && op_u <= 32'd15):  op_cls = C_ALU;
            (op_u == 32'd16):                   op_cls = C_JMP;
            (op_u == 32'd17):                   op_cls = C_BCOND;
            (op_u == 32'd18):                   op_cls = C_HALT;
            default:                            op_cls = C_ILL;
        endcase
    end

    // Evaluate the branch condition against {N,Z,C,V}.
    always_comb begin
        cond_true = 1'b0;
        unique case (COND)
            3'd0: cond_true = FLAGS[2];
            3'd1: cond_true = !FLAGS[2];
            3'd2: cond_true = FLAGS[3] ^ FLAGS[0];
            3'd3: cond_true = !(FLAGS[3] ^ FLAGS[0]);
            3'd4: cond_true = FLAGS[1];
            3'd5: cond_true = !FLAGS[1];
            3'd6: cond_true = FLAGS[3];
            3'd7: cond_true = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_n;
    end

    // Wait counter runs only in FETCH; class/taken captured in DECODE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wait_cnt <= '0;
            cls      <= C_NOP;
            taken    <= 1'b0;
        end else begin
            if (state != S_FETCH)
                wait_cnt <= '0;
            else if (!MEM_READY)
                wait_cnt <= wait_cnt + 8'd1;
            if (state == S_DECODE) begin
                cls   <= op_cls;
                taken <= (op_cls == C_BCOND) && cond_true;
            end
        end
    end

    // Next-state logic; RUN is only looked at between instructions.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:
                if (RUN) state_n = S_FETCH;
            S_FETCH:
                if (MEM_READY)                  state_n = S_DECODE;
                else if (wait_cnt == LAST_WAIT) state_n = S_ERR;
            S_DECODE:
                if (op_cls == C_ILL)       state_n = S_ERR;
                else if (op_cls == C_HALT) state_n = S_HALT;
                else                       state_n = S_EXEC;
            S_EXEC:
                state_n = S_PCUPD;
            S_PCUPD:
                if (!RUN)          state_n = S_IDLE;
                else if (STEP_MODE) state_n = S_PAUSE;
                else               state_n = S_FETCH;
            S_PAUSE:
                if (STEP)      state_n = S_FETCH;
                else if (!RUN) state_n = S_IDLE;
            S_HALT:  state_n = S_HALT;
            S_ERR:   state_n = S_ERR;
            default: state_n = S_ERR;
        endcase
    end

    // Moore outputs, except IR_LOAD which follows the fetch handshake.
    always_comb begin
        MEM_REQ    = (state == S_FETCH);
        IR_LOAD    = (state == S_FETCH) && MEM_READY;
        REG_WE     = (state == S_EXEC) && (cls == C_ALU);
        FLAGS_LOAD = (state == S_EXEC) && (cls == C_ALU);
        WPC        = (state == S_PCUPD);
        UC         = (state == S_PCUPD) && (cls == C_JMP);
        ALU_TAKEN  = (state == S_PCUPD) && (cls == C_BCOND) && taken;
        HALTED     = (state == S_HALT);
        ERROR      = (state == S_ERR);
        STATE      = state;
    end

endmodule

// File: tb/tb_secuenciador_control.sv
// tb_secuenciador_control: random programs vs a per-instruction model.
// Expected strobes are queued by the driver and popped by a monitor.
module tb_secuenciador_control;

    localparam int MT = 15;

    logic       CLK = 1'b0;
    logic       RESET, RUN, STEP_MODE, STEP, MEM_READY;
    logic [4:0] OPCODE;
    logic [2:0] COND;
    logic [3:0] FLAGS;
    logic       MEM_REQ, IR_LOAD, REG_WE, FLAGS_LOAD, WPC, UC, ALU_TAKEN;
    logic       HALTED, ERROR;
    logic [2:0] STATE;

    secuenciador_control #(.OPW(5), .MEM_TIMEOUT(MT)) dut (
        .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP_MODE(STEP_MODE),
        .STEP(STEP), .MEM_READY(MEM_READY), .OPCODE(OPCODE),
        .COND(COND), .FLAGS(FLAGS), .MEM_REQ(MEM_REQ),
        .IR_LOAD(IR_LOAD), .REG_WE(REG_WE), .FLAGS_LOAD(FLAGS_LOAD),
        .WPC(WPC), .UC(UC), .ALU_TAKEN(ALU_TAKEN), .HALTED(HALTED),
        .ERROR(ERROR), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int t;
        bit uc;
        bit tk;
    } pc_ev_t;

    int     ir_q[$];
    int     we_q[$];
    pc_ev_t pc_q[$];
    int     total = 0;
    int     bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: strobe seen with nothing expected (cyc %0d)", name, cyc);
    endtask

    // Branch rule table over {N,Z,C,V}.
    function automatic bit cond_ok(input logic [2:0] c, input logic [3:0] f);
        bit n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            3'd0: return z;
            3'd1: return !z;
            3'd2: return n != v;
            3'd3: return n == v;
            3'd4: return cf;
            3'd5: return !cf;
            3'd6: return n;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int outs();
        return int'({MEM_REQ, IR_LOAD, REG_WE, FLAGS_LOAD, WPC, UC,
                     ALU_TAKEN, HALTED, ERROR, STATE});
    endfunction

    // Monitor: every strobe must match the next queued expectation.
    initial begin
        forever begin
            @(negedge CLK);
            #1;
            if (UC || ALU_TAKEN)
                check("jump_needs_wpc", int'(WPC), 1);
            if (IR_LOAD) begin
                if (ir_q.size() == 0) unexpected("ir_load");
                else check("ir_load_time", cyc, ir_q.pop_front());
            end
            if (REG_WE || FLAGS_LOAD) begin
                check("flags_load_eq_reg_we", int'(FLAGS_LOAD), int'(REG_WE));
                if (we_q.size() == 0) unexpected("reg_we");
                else check("reg_we_time", cyc, we_q.pop_front());
            end
            if (WPC) begin
                if (pc_q.size() == 0) unexpected("wpc");
                else begin
                    pc_ev_t e;
                    e = pc_q.pop_front();
                    check("wpc_time", cyc, e.t);
                    check("uc", int'(UC), int'(e.uc));
                    check("alu_taken", int'(ALU_TAKEN), int'(e.tk));
                end
            end
        end
    end

    task automatic do_reset();
        RESET = 1'b1; RUN = 1'b0; STEP = 1'b0; STEP_MODE = 1'b0;
        MEM_READY = 1'b0;
        @(negedge CLK);
        check("reset_outputs", outs(), 0);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic start();
        RUN = 1'b1;
        @(negedge CLK);
        check("enter_fetch", int'(STATE), 1);
    endtask

    // Called in the first FETCH cycle; returns in the PCUPD cycle.
    task automatic do_instr(input logic [4:0] op, input logic [2:0] cd,
                            input logic [3:0] fl, input int w);
        pc_ev_t e;
        OPCODE = op; COND = cd; FLAGS = fl; MEM_READY = 1'b0;
        check("mem_req", int'(MEM_REQ), 1);
        repeat (w) @(negedge CLK);
        MEM_READY = 1'b1;
        ir_q.push_back(cyc);
        if (op >= 5'd1 && op <= 5'd15) we_q.push_back(cyc + 2);
        e.t  = cyc + 3;
        e.uc = (op == 5'd16);
        e.tk = (op == 5'd17) && cond_ok(cd, fl);
        pc_q.push_back(e);
        @(negedge CLK);
        MEM_READY = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_term(input logic [4:0] op, input int st);
        OPCODE = op; MEM_READY = 1'b1;
        ir_q.push_back(cyc);
        @(negedge CLK);
        MEM_READY = 1'b0;
        @(negedge CLK);
        check("term_state", int'(STATE), st);
        repeat (10) @(negedge CLK);
        MEM_READY = 1'b1;
        @(negedge CLK);
        MEM_READY = 1'b0;
        check("term_state_held", int'(STATE), st);
        check("halted", int'(HALTED), int'(st == 6));
        check("error", int'(ERROR), int'(st == 7));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        OPCODE = '0; COND = '0; FLAGS = '0;
        do_reset();

        start();
        do_instr(5'd3, 3'd0, 4'b0000, 0);
        check("pcupd_state", int'(STATE), 4);
        @(negedge CLK);
        check("back_to_fetch", int'(STATE), 1);
        do_instr(5'd17, 3'd0, 4'b0100, 0);
        @(negedge CLK);
        do_instr(5'd17, 3'd0, 4'b0000, 1);
        @(negedge CLK);
        do_instr(5'd16, 3'd5, 4'b0010, 2);
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            do_instr(5'($urandom_range(0, 17)), 3'($urandom_range(0, 7)),
                     4'($urandom_range(0, 15)), $urandom_range(0, 4));
        end
        RUN = 1'b0;
        @(negedge CLK);
        check("run_drop_idle", int'(STATE), 0);

        start();
        do_instr(5'd5, 3'd0, 4'b0000, 0);
        STEP_MODE = 1'b1;
        @(negedge CLK);
        check("pause_entry", int'(STATE), 5);
        repeat (10) @(negedge CLK);
        check("pause_held", int'(STATE), 5);
        STEP = 1'b1;
        @(negedge CLK);
        STEP = 1'b0;
        check("step_fetch", int'(STATE), 1);
        do_instr(5'd16, 3'd0, 4'b0000, 1);
        @(negedge CLK);
        check("pause_again", int'(STATE), 5);
        RUN = 1'b0; STEP = 1'b1;
        @(negedge CLK);
        STEP = 1'b0;
        check("step_priority", int'(STATE), 1);
        do_instr(5'd9, 3'd0, 4'b0000, 0);
        @(negedge CLK);
        check("finish_then_idle", int'(STATE), 0);
        STEP_MODE = 1'b0;
        start();
        do_instr(5'd1, 3'd0, 4'b0000, 0);
        STEP_MODE = 1'b1;
        @(negedge CLK);
        RUN = 1'b0;
        @(negedge CLK);
        check("pause_to_idle", int'(STATE), 0);

        do_reset();
        start();
        MEM_READY = 1'b0;
        repeat (MT - 1) @(negedge CLK);
        check("timeout_last_fetch", int'(STATE), 1);
        @(negedge CLK);
        check("timeout_error", int'(STATE), 7);
        check("timeout_error_flag", int'(ERROR), 1);
        repeat (5) @(negedge CLK);
        check("error_sticky", int'(STATE), 7);
        do_reset();
        start();
        do_instr(5'd7, 3'd0, 4'b0000, MT - 1);
        RUN = 1'b0;
        @(negedge CLK);
        check("late_ready_ok", int'(STATE), 0);

        do_reset();
        start();
        do_term(5'd18, 6);
        do_reset();
        start();
        do_term(5'd25, 7);
        do_reset();

        start();
        OPCODE = 5'd3; MEM_READY = 1'b1;
        ir_q.push_back(cyc);
        we_q.push_back(cyc + 2);
        @(negedge CLK);
        MEM_READY = 1'b0;
        @(negedge CLK);
        check("exec_state", int'(STATE), 3);
        RESET = 1'b1;
        @(negedge CLK);
        check("reset_in_exec", outs(), 0);
        RESET = 1'b0;
        @(negedge CLK);
        check("fetch_after_reset", int'(STATE), 1);
        RESET = 1'b1;
        @(negedge CLK);
        check("reset_in_fetch", outs(), 0);
        RESET = 1'b0; RUN = 1'b0;

        repeat (4) @(negedge CLK);
        check("ir_q_drained", ir_q.size(), 0);
        check("we_q_drained", we_q.size(), 0);
        check("pc_q_drained", pc_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
